regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the pipelined core. It replaces the fixed 2R/1W 32x32 file and adds configurable width, depth and port counts. It provides same-cycle write-to-read bypass, a per-register busy scoreboard for the hazard unit, and a sequenced, counter-driven initialisation after reset. It sits between decode (reads, busy marking) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of read ports
NWR, 1, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never marked busy
INIT_MODE, 1, 0 = initialise every entry to 0; 1 = entry i initialised to value i (entry 0 stays 0 when ZERO_REG=1)
AW, $clog2(NREGS), derived localparam: address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, combinational
rd_busy  out  NRD  scoreboard bit of each read address, combinational
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  packed write addresses
wr_data  in  NWR*XLEN  packed write data
mark_en  in  1  decode marks a destination as pending
mark_addr  in  AW  destination register to mark busy
init_done  out  1  high once initialisation has completed

Behaviour:
- Reset: rst_n sampled low at a rising edge clears all busy bits, sets init_done=0, loads init counter with 0 and enters INIT. Reset asserted mid-INIT or mid-READY restarts INIT from entry 0.
- FSM states: INIT and READY.
- INIT: each cycle writes the init value (per INIT_MODE) to entry[cnt] and increments cnt. The cycle cnt==NREGS-1 is written, the state moves to READY and init_done rises the next cycle. INIT therefore takes exactly NREGS cycles after reset release.
- During INIT: wr_en and mark_en are ignored, rd_data is all 0 and rd_busy is all 1, so the hazard unit stalls.
- READY, writes: for each port p with wr_en[p] and a legal address, entry[wr_addr[p]] <= wr_data[p] at the edge. If ZERO_REG=1, writes to address 0 are dropped.
- Write conflict: same address on several enabled ports -> the highest-index port wins, both for storage and for bypass.
- Read: rd_data[k] = entry[rd_addr[k]]. Bypass: if any enabled write port targets rd_addr[k] in the same cycle, rd_data[k] takes that port's wr_data (highest index wins). Address 0 with ZERO_REG=1 always reads 0 and is never bypassed.
- Scoreboard: mark_en sets busy[mark_addr] at the edge. Each enabled write clears busy[wr_addr[p]] at the edge.
- Simultaneous mark and write to the same address: set wins, because a new producer supersedes the old one.
- rd_busy[k] = busy[rd_addr[k]], using the registered value with no same-cycle bypass of mark/clear. rd_busy for address 0 is always 0 when ZERO_REG=1.
- Latency: reads are 0-cycle (combinational); writes, marks and clears are visible in state 1 cycle later. Bypass makes written data visible to reads in the same cycle.
- No X propagation: every entry is defined after INIT, and there are no initial blocks in synthesisable code.

Decomposition:
- Shared package rf_pkg holds: default XLEN/NREGS constants; the state enum {RF_INIT, RF_READY}; a function init_value(idx, mode).
- One natural sub-module, rf_scoreboard: NREGS busy bits with mark/clear priority logic and NRD lookup ports.
- Storage, bypass and the INIT FSM stay in regfile_mp.

Test Plan:
- Init sequencing: deassert rst_n at cycle 0 with NREGS=32 -> init_done low for exactly 32 cycles, then high. Read x5 -> 5 (INIT_MODE=1); x0 -> 0.
- Write + bypass: wr_en=1, wr_addr=7, wr_data=0xCAFEBABE, rd_addr[0]=7 in the same cycle -> rd_data[0]=0xCAFEBABE that cycle. Next cycle with wr_en=0 -> still 0xCAFEBABE.
- Zero register and multi-port conflict (NWR=2): port0 writes x3=0x11 and port1 writes x3=0x22 in the same cycle -> x3 reads 0x22. Writing x0=0xFFFFFFFF -> x0 reads 0.
- Scoreboard: mark x9 -> rd_busy for x9 is 1 next cycle. Write x9 -> busy clears next cycle. Mark x9 and write x9 in the same cycle -> x9 stays busy.
- Reset mid-operation: assert rst_n low at INIT cycle 10, and separately in READY with x4 busy -> init restarts with a full 32-cycle count, all busy bits are 0, and wr_en/mark_en during INIT have no effect.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, FSM states and init helper for the register file
package rf_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;

   typedef enum logic {
      RF_INIT  = 1'b0,
      RF_READY = 1'b1
   } rf_state_t;

   // Value loaded into entry idx during initialisation; callers size-cast to XLEN
   function automatic logic [63:0] init_value(input int unsigned idx, input int unsigned mode);
      if (mode == 1) begin
         return 64'(idx);
      end
      return '0;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with mark/clear priority and lookup ports
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS    = RF_NREGS,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mark_en,
   input  logic [AW-1:0]     mark_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   input  logic [NRD*AW-1:0] lookup_addr,
   output logic [NRD-1:0]    lookup_busy
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [AW-1:0]    look_a;

   // Next busy vector: clears first, then mark so a new producer overrides a retiring one
   always_comb begin
      busy_nxt = busy;
      for (int p = 0; p < NWR; p++) begin
         if (clr_en[p]) begin
            busy_nxt[clr_addr[p*AW +: AW]] = 1'b0;
         end
      end
      if (mark_en) begin
         busy_nxt[mark_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_nxt[0] = 1'b0;
      end
   end

   // Busy register, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Lookup uses registered state only; the zero register never reports busy
   always_comb begin
      lookup_busy = '0;
      look_a      = '0;
      for (int k = 0; k < NRD; k++) begin
         look_a         = lookup_addr[k*AW +: AW];
         lookup_busy[k] = busy[look_a] & ~((ZERO_REG != 0) && (look_a == '0));
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, busy scoreboard and sequenced init
module regfile_mp
   import rf_pkg::*;
#(
   parameter int XLEN      = RF_XLEN,
   parameter int NREGS     = RF_NREGS,
   parameter int NRD       = 2,
   parameter int NWR       = 1,
   parameter int ZERO_REG  = 1,
   parameter int INIT_MODE = 1,
   localparam int AW       = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                mark_en,
   input  logic [AW-1:0]       mark_addr,
   output logic                init_done
);

   rf_state_t        state;
   logic [AW-1:0]    cnt;
   logic [XLEN-1:0]  mem [NREGS];
   logic             ready;
   logic [NWR-1:0]   wr_act;
   logic             mark_act;
   logic [XLEN-1:0]  init_word;
   logic [NRD-1:0]   sb_busy;
   logic [AW-1:0]    rd_a;
   logic [XLEN-1:0]  rd_v;

   assign ready     = (state == RF_READY);
   assign init_word = XLEN'(init_value(32'(cnt), INIT_MODE));
   assign mark_act  = ready & mark_en;

   // Effective write enables: nothing during INIT, and zero-register writes dropped
   always_comb begin
      wr_act = '0;
      for (int p = 0; p < NWR; p++) begin
         wr_act[p] = ready & wr_en[p] &
                     ~((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
      end
   end

   // INIT/READY sequencer: one entry per cycle, init_done rises with READY
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RF_INIT;
         cnt       <= '0;
         init_done <= 1'b0;
      end else begin
         case (state)
            RF_INIT: begin
               cnt <= cnt + AW'(1);
               if (cnt == AW'(NREGS - 1)) begin
                  state     <= RF_READY;
                  init_done <= 1'b1;
               end
            end
            RF_READY: begin
               state <= RF_READY;
            end
            default: begin
               state <= RF_INIT;
            end
         endcase
      end
   end

   // Storage: init fill, else port writes with the highest-index port landing last
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == RF_INIT) begin
            mem[cnt] <= init_word;
         end else begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_act[p]) begin
                  mem[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
               end
            end
         end
      end
   end

   // Combinational read with same-cycle write bypass, zero register and INIT masking
   always_comb begin
      rd_data = '0;
      rd_a    = '0;
      rd_v    = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_a = rd_addr[k*AW +: AW];
         rd_v = mem[rd_a];
         for (int p = 0; p < NWR; p++) begin
            if (wr_act[p] && (wr_addr[p*AW +: AW] == rd_a)) begin
               rd_v = wr_data[p*XLEN +: XLEN];
            end
         end
         if ((ZERO_REG != 0) && (rd_a == '0)) begin
            rd_v = '0;
         end
         if (!ready) begin
            rd_v = '0;
         end
         rd_data[k*XLEN +: XLEN] = rd_v;
      end
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .mark_en     (mark_act),
      .mark_addr   (mark_addr),
      .clr_en      (wr_act),
      .clr_addr    (wr_addr),
      .lookup_addr (rd_addr),
      .lookup_busy (sb_busy)
   );

   // Hazard unit must stall during INIT, so every port reports busy
   assign rd_busy = ready ? sb_busy : '1;

endmodule
